// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter for the single register-bank write port.
// Grants one requester per cycle and returns registered ACK, one-hot WR_CE and WR_DATA.
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_DATA,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDR,
    input  logic                           HOLD,
    output logic [NUM_REGS-1:0]            WR_CE,
    output logic [DATA_WIDTH-1:0]          WR_DATA,
    output logic [NUM_REQ-1:0]             ACK,
    output logic                           BUSY,
    output logic                           ERR
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]         ptr;
    logic [PW-1:0]         g;
    logic [PW-1:0]         ptr_next;
    logic                  found;
    logic                  grant;
    logic                  in_range;
    logic [NUM_REQ-1:0]    elig;
    logic [ADDR_WIDTH-1:0] addr_g;
    logic [DATA_WIDTH-1:0] data_g;

    // The registered ACK doubles as the mask: a requester acknowledged this
    // cycle may still show REQ while it drops it, so it must not win again.
    assign elig = REQ & ~ACK;
    assign BUSY = |elig;

    always_comb begin
        found = 1'b0;
        g = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && elig[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                g = PW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    assign grant    = found && !HOLD;
    assign addr_g   = REQ_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_g   = REQ_DATA[g*DATA_WIDTH +: DATA_WIDTH];
    assign in_range = int'(addr_g) < NUM_REGS;
    assign ptr_next = (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            WR_CE   <= '0;
            WR_DATA <= '0;
            ACK     <= '0;
            ERR     <= 1'b0;
            ptr     <= '0;
        end else begin
            ACK   <= grant ? NUM_REQ'(1) << g : '0;
            WR_CE <= (grant && in_range) ? NUM_REGS'(1) << addr_g : '0;
            if (grant) begin
                WR_DATA <= data_g;
                ptr     <= ptr_next;
            end
            if (grant && !in_range)
                ERR <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: directed stimulus with a cycle-tagged scoreboard queue;
// a negedge monitor pops and compares expectations as the DUT outputs become due.
module tb_reg_write_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int NG = 3;
    localparam int AW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*DW-1:0] req_data = '0;
    logic [NR*AW-1:0] req_addr = '0;
    logic             hold = 1'b0;
    logic [NG-1:0]    wr_ce;
    logic [DW-1:0]    wr_data;
    logic [NR-1:0]    ack;
    logic             busy;
    logic             err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        string       name;
        logic [3:0]  ack;
        logic [2:0]  ce;
        logic [7:0]  data;
        logic        cmp_data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    reg_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .NUM_REGS(NG), .ADDR_WIDTH(AW)) dut (
        .CLK(clk), .RST(rst), .REQ(req), .REQ_DATA(req_data), .REQ_ADDR(req_addr),
        .HOLD(hold), .WR_CE(wr_ce), .WR_DATA(wr_data), .ACK(ack), .BUSY(busy), .ERR(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, want);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, ".ack"}, 32'(ack), 32'(e.ack));
                chk({e.name, ".ce"}, 32'(wr_ce), 32'(e.ce));
                chk({e.name, ".err"}, 32'(err), 32'(e.err));
                if (e.cmp_data)
                    chk({e.name, ".data"}, 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic step(input string name, input logic [3:0] r, input logic h, input logic rs,
                        input logic [3:0] eack, input logic [2:0] ece, input logic [7:0] edat,
                        input logic eerr);
        exp_t e;
        @(posedge clk);
        #1;
        req = r;
        hold = h;
        rst = rs;
        e.due = cyc + 1;
        e.name = name;
        e.ack = eack;
        e.ce = ece;
        e.data = edat;
        e.cmp_data = (eack != 0) || rs;
        e.err = eerr;
        sb.push_back(e);
    endtask

    task automatic check_busy(input string name, input logic want);
        #1;
        chk(name, 32'(busy), 32'(want));
    endtask

    initial begin
        set_req(0, 2'd2, 8'hA5);
        set_req(1, 2'd2, 8'h22);
        set_req(2, 2'd0, 8'h33);
        set_req(3, 2'd2, 8'h44);
        step("rst", 4'b0000, 0, 1, 4'b0000, 3'b000, 8'h00, 0);
        // single request then drop
        step("t1_grant", 4'b0001, 0, 0, 4'b0001, 3'b100, 8'hA5, 0);
        step("t1_idle", 4'b0000, 0, 0, 4'b0000, 3'b000, 8'h00, 0);
        // all requesting: strict rotation
        step("t2_rst", 4'b0000, 0, 1, 4'b0000, 3'b000, 8'h00, 0);
        set_req(0, 2'd1, 8'h11);
        step("t2_g0", 4'b1111, 0, 0, 4'b0001, 3'b010, 8'h11, 0);
        step("t2_g1", 4'b1111, 0, 0, 4'b0010, 3'b100, 8'h22, 0);
        check_busy("t2_busy", 1'b1);
        step("t2_g2", 4'b1111, 0, 0, 4'b0100, 3'b001, 8'h33, 0);
        step("t2_g3", 4'b1111, 0, 0, 4'b1000, 3'b100, 8'h44, 0);
        step("t2_g0b", 4'b1111, 0, 0, 4'b0001, 3'b010, 8'h11, 0);
        step("t2_idle", 4'b0000, 0, 0, 4'b0000, 3'b000, 8'h00, 0);
        check_busy("t2_busy_idle", 1'b0);
        // lone continuous requester: every other cycle
        step("t3_a", 4'b0100, 0, 0, 4'b0100, 3'b001, 8'h33, 0);
        step("t3_b", 4'b0100, 0, 0, 4'b0000, 3'b000, 8'h00, 0);
        check_busy("t3_busy_masked", 1'b0);
        step("t3_c", 4'b0100, 0, 0, 4'b0100, 3'b001, 8'h33, 0);
        check_busy("t3_busy_pending", 1'b1);
        step("t3_d", 4'b0100, 0, 0, 4'b0000, 3'b000, 8'h00, 0);
        step("t3_e", 4'b0100, 0, 0, 4'b0100, 3'b001, 8'h33, 0);
        step("t3_f", 4'b0100, 0, 0, 4'b0000, 3'b000, 8'h00, 0);
        step("t3_idle", 4'b0000, 0, 0, 4'b0000, 3'b000, 8'h00, 0);
        // out-of-range address: ACK without CE, sticky ERR
        set_req(1, 2'd3, 8'h3C);
        step("t4_oor", 4'b0010, 0, 0, 4'b0010, 3'b000, 8'h3C, 1);
        step("t4_sticky", 4'b0000, 0, 0, 4'b0000, 3'b000, 8'h00, 1);
        step("t4_valid", 4'b0001, 0, 0, 4'b0001, 3'b010, 8'h11, 1);
        step("t4_idle", 4'b0000, 0, 0, 4'b0000, 3'b000, 8'h00, 1);
        step("t4_rst", 4'b0000, 0, 1, 4'b0000, 3'b000, 8'h00, 0);
        // HOLD blocks grants, PTR preserved
        set_req(1, 2'd2, 8'h22);
        step("t5_hold1", 4'b0011, 1, 0, 4'b0000, 3'b000, 8'h00, 0);
        step("t5_hold2", 4'b0011, 1, 0, 4'b0000, 3'b000, 8'h00, 0);
        step("t5_hold3", 4'b0011, 1, 0, 4'b0000, 3'b000, 8'h00, 0);
        step("t5_g0", 4'b0011, 0, 0, 4'b0001, 3'b010, 8'h11, 0);
        step("t5_g1", 4'b0010, 0, 0, 4'b0010, 3'b100, 8'h22, 0);
        step("t5_g2", 4'b0100, 0, 0, 4'b0100, 3'b001, 8'h33, 0);
        step("t5_hold_after", 4'b0000, 1, 0, 4'b0000, 3'b000, 8'h00, 0);
        // reset with a request pending clears PTR and suppresses the grant
        step("t6_rst", 4'b1001, 0, 1, 4'b0000, 3'b000, 8'h00, 0);
        step("t6_g0", 4'b1001, 0, 0, 4'b0001, 3'b010, 8'h11, 0);
        step("t6_g3", 4'b1000, 0, 0, 4'b1000, 3'b100, 8'h44, 0);
        step("t6_idle", 4'b0000, 0, 0, 4'b0000, 3'b000, 8'h00, 0);
        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
